// File: rtl/fpro_bus_master.sv
// FPro bus initiator: queued single-word read/write commands, each issued as a
// one-cycle bus strobe, with read data returned on a valid/ready response port.
module fpro_bus_master #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [21:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        fp_mmio_cs,
  output logic        fp_video_cs,
  output logic        fp_wr,
  output logic        fp_rd,
  output logic [20:0] fp_addr,
  output logic [31:0] fp_wr_data,
  input  logic [31:0] fp_rd_data,
  output logic        idle,
  output logic [15:0] txn_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic        wr;
    logic [21:0] addr;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  state_t        state, state_nxt;

  assign cmd_ready = (count != CNT_FULL);
  assign push      = cmd_valid & cmd_ready;
  assign head      = fifo_mem[rd_ptr];
  assign idle      = (count == '0) && (state == IDLE) && !rsp_valid;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = fp_rd ? RESP : IDLE;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are loaded on the pop edge so the strobe lines up with ISSUE;
  // the strobe registers themselves remember the command type during ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      fp_mmio_cs  <= 1'b0;
      fp_video_cs <= 1'b0;
      fp_wr       <= 1'b0;
      fp_rd       <= 1'b0;
      fp_addr     <= '0;
      fp_wr_data  <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      txn_count   <= '0;
    end else if (pop) begin
      fp_addr     <= head.addr[20:0];
      fp_wr_data  <= head.data;
      fp_wr       <= head.wr;
      fp_rd       <= ~head.wr;
      fp_mmio_cs  <= ~head.addr[21];
      fp_video_cs <= head.addr[21];
      txn_count   <= txn_count + 16'd1;
    end else if (state == ISSUE) begin
      fp_mmio_cs  <= 1'b0;
      fp_video_cs <= 1'b0;
      fp_wr       <= 1'b0;
      fp_rd       <= 1'b0;
      if (fp_rd) begin
        rsp_valid <= 1'b1;
        rsp_data  <= fp_video_cs ? '0 : fp_rd_data;
      end
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpro_bus_master.sv
// Directed bench for fpro_bus_master with a small combinational slot model.
module tb_fpro_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        fp_mmio_cs;
  logic        fp_video_cs;
  logic        fp_wr;
  logic        fp_rd;
  logic [20:0] fp_addr;
  logic [31:0] fp_wr_data;
  logic [31:0] fp_rd_data;
  logic        idle;
  logic [15:0] txn_count;

  int errors = 0;
  int checks = 0;
  int obs    = 0;

  always #5 clk = ~clk;

  // Slot model: address 0x81 holds 0x12345678, everything else reads all-ones.
  assign fp_rd_data = (fp_addr == 21'h81) ? 32'h1234_5678 : 32'hFFFF_FFFF;

  fpro_bus_master #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .fp_mmio_cs(fp_mmio_cs), .fp_video_cs(fp_video_cs), .fp_wr(fp_wr),
    .fp_rd(fp_rd), .fp_addr(fp_addr), .fp_wr_data(fp_wr_data),
    .fp_rd_data(fp_rd_data), .idle(idle), .txn_count(txn_count)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic wr, input logic [21:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 32'({fp_mmio_cs, fp_video_cs, fp_wr, fp_rd}), 32'h0);
  endtask

  task automatic step_mon();
    step();
    if (fp_wr) begin
      check("stream_addr", 32'(fp_addr), 32'(768 + obs));
      check("stream_data", fp_wr_data, 32'hC0DE_0000 + 32'(obs));
      check("stream_cs", 32'({fp_mmio_cs, fp_video_cs, fp_rd}), 32'b100);
      obs++;
    end
  endtask

  initial begin
    int budget;
    logic saw_full;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    step(); step();

    // Reset state
    check_quiet("rst_strobes");
    check("rst_addr", 32'(fp_addr), 32'h0);
    check("rst_wdata", fp_wr_data, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_txn", 32'(txn_count), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_idle", 32'(idle), 32'h1);
    reset = 1'b0;
    step();

    // MMIO write: strobe two cycles after acceptance, for one cycle
    set_cmd(1'b1, 22'h000040, 32'hDEAD_BEEF);
    step(); cmd_valid = 1'b0;
    check_quiet("w1_n1_quiet");
    step();
    check("w1_cs_wr", 32'({fp_mmio_cs, fp_video_cs, fp_wr, fp_rd}), 32'b1010);
    check("w1_addr", 32'(fp_addr), 32'h40);
    check("w1_data", fp_wr_data, 32'hDEAD_BEEF);
    check("w1_txn", 32'(txn_count), 32'd1);
    step();
    check_quiet("w1_n3_quiet");
    check("w1_idle", 32'(idle), 32'h1);

    // MMIO read with stalled consumer
    rsp_ready = 1'b0;
    set_cmd(1'b0, 22'h000081, 32'h0);
    step(); cmd_valid = 1'b0;
    step();
    check("r1_cs_rd", 32'({fp_mmio_cs, fp_video_cs, fp_wr, fp_rd}), 32'b1001);
    check("r1_addr", 32'(fp_addr), 32'h81);
    check("r1_valid_early", 32'(rsp_valid), 32'h0);
    step();
    check("r1_valid", 32'(rsp_valid), 32'h1);
    check("r1_data", rsp_data, 32'h1234_5678);
    check_quiet("r1_strobe_off");
    for (int i = 0; i < 4; i++) begin
      step();
      check("r1_hold_valid", 32'(rsp_valid), 32'h1);
      check("r1_hold_data", rsp_data, 32'h1234_5678);
    end
    rsp_ready = 1'b1;
    step();
    check("r1_valid_drop", 32'(rsp_valid), 32'h0);
    check("r1_idle", 32'(idle), 32'h1);
    check("r1_txn", 32'(txn_count), 32'd2);

    // Video write then video read (read returns zero)
    set_cmd(1'b1, 22'h200010, 32'hA5A5_A5A5);
    step();
    set_cmd(1'b0, 22'h200010, 32'h0);
    step(); cmd_valid = 1'b0;
    check("vw_cs_wr", 32'({fp_mmio_cs, fp_video_cs, fp_wr, fp_rd}), 32'b0110);
    check("vw_addr", 32'(fp_addr), 32'h10);
    check("vw_data", fp_wr_data, 32'hA5A5_A5A5);
    step();
    check_quiet("vw_gap");
    step();
    check("vr_cs_rd", 32'({fp_mmio_cs, fp_video_cs, fp_wr, fp_rd}), 32'b0101);
    step();
    check("vr_valid", 32'(rsp_valid), 32'h1);
    check("vr_data", rsp_data, 32'h0);
    step();
    check("vr_done", 32'(rsp_valid), 32'h0);
    check("vr_idle", 32'(idle), 32'h1);
    check("vr_txn", 32'(txn_count), 32'd4);

    // Fill FIFO behind a stalled read; extra push while full is dropped
    rsp_ready = 1'b0;
    set_cmd(1'b0, 22'h000081, 32'h0);
    step();
    for (int i = 0; i < 8; i++) begin
      set_cmd(1'b1, 22'(256 + i), 32'h5000_0000 + 32'(i));
      step();
    end
    check("full_ready", 32'(cmd_ready), 32'h0);
    set_cmd(1'b1, 22'h0001FF, 32'hBAD0_BAD0);
    step(); cmd_valid = 1'b0;
    check("full_ready_hold", 32'(cmd_ready), 32'h0);
    check("full_rsp_valid", 32'(rsp_valid), 32'h1);
    check("full_rsp_data", rsp_data, 32'h1234_5678);
    rsp_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) check("drain_ready", 32'(cmd_ready), 32'h1);
      check("drain_wr", 32'({fp_mmio_cs, fp_wr, fp_rd}), 32'b110);
      check("drain_addr", 32'(fp_addr), 32'(256 + i));
      check("drain_data", fp_wr_data, 32'h5000_0000 + 32'(i));
      step();
      check_quiet("drain_gap");
    end
    step();
    check_quiet("drain_no_extra");
    check("drain_idle", 32'(idle), 32'h1);
    check("drain_txn", 32'(txn_count), 32'd13);

    // Push every cycle: simultaneous push/pop and pointer wrap
    saw_full = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_cmd(1'b1, 22'(768 + k), 32'hC0DE_0000 + 32'(k));
      budget = 0;
      while (!cmd_ready && budget < 50) begin
        saw_full = 1'b1;
        step_mon();
        budget++;
      end
      step_mon();
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 60 && obs < 20; c++) step_mon();
    check("stream_count", 32'(obs), 32'd20);
    check("stream_saw_full", 32'(saw_full), 32'h1);
    step();
    check("stream_idle", 32'(idle), 32'h1);
    check("stream_txn", 32'(txn_count), 32'd33);

    // Reset during RESP with three commands queued
    rsp_ready = 1'b0;
    set_cmd(1'b0, 22'h000081, 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 22'(928 + i), 32'h7700_0000 + 32'(i));
      step();
    end
    cmd_valid = 1'b0;
    check("mr_valid", 32'(rsp_valid), 32'h1);
    check("mr_ready_q", 32'(cmd_ready), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    check_quiet("mr_strobes");
    check("mr_cmd_ready", 32'(cmd_ready), 32'h1);
    check("mr_idle", 32'(idle), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_quiet("mr_no_issue");
    end
    check("mr_txn", 32'(txn_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
